display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 108 ++++++++++
 tb/tb_display_scan_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Six-digit multiplexed HH:MM:SS scan controller driving a shared two-digit 7-seg decoder.
// Shadow registers latch once per frame so a displayed frame never tears.
`timescale 1ns/1ps
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned BLINK_STEPS = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] hour,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  input  logic [1:0] blink_sel,
  output logic [6:0] dec_val,
  input  logic [6:0] dec_led_1,
  input  logic [6:0] dec_led_2,
  output logic [6:0] seg,
  output logic [5:0] an
);

  localparam int unsigned DivW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
  localparam logic [DivW-1:0]   DivMax   = DivW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_STEPS - 1);

  logic [DivW-1:0]   div_q, div_d;
  logic [2:0]        dig_q, dig_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic              started_q;
  logic [6:0]        sh_sec_q, sh_min_q, sh_hour_q;
  logic [6:0]        seg_q, seg_d;
  logic [5:0]        an_q, an_d;
  logic              step, latch, blank;
  logic [1:0]        grp;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  always_comb begin
    div_d         = div_q + DivW'(1);
    dig_d         = dig_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    step          = (div_q == DivMax);
    if (step) begin
      div_d = '0;
      dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end
    // First edge after reset, then only on the 5->0 frame wrap.
    latch = !started_q || (step && (dig_q == 3'd5));
  end

  always_comb begin
    grp = dig_q[2:1];
    case (grp)
      2'd0:    dec_val = sh_sec_q;
      2'd1:    dec_val = sh_min_q;
      default: dec_val = sh_hour_q;
    endcase
    blank = blink_phase_q && (blink_sel == grp + 2'd1);
    seg_d = dig_q[0] ? dec_led_2 : dec_led_1;
    an_d  = ~(6'b000001 << dig_q);
    if (blank) begin
      seg_d = 7'h7F;
      an_d  = 6'h3F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      dig_q         <= 3'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      started_q     <= 1'b0;
      sh_sec_q      <= 7'd0;
      sh_min_q      <= 7'd0;
      sh_hour_q     <= 7'd0;
      seg_q         <= 7'h7F;
      an_q          <= 6'h3F;
    end else begin
      div_q         <= div_d;
      dig_q         <= dig_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      started_q     <= 1'b1;
      seg_q         <= seg_d;
      an_q          <= an_d;
      if (latch) begin
        sh_sec_q  <= sat99(sec);
        sh_min_q  <= sat99(min);
        sh_hour_q <= sat99(hour);
      end
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: a cycle-count model pushes expected outputs each posedge,
// the checker pops and compares them on the following negedge.
`timescale 1ns/1ps
module tb_display_scan_ctrl;

  localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] hour, min, sec;
  logic [1:0] blink_sel;
  logic [6:0] dec_val, dec_led_1, dec_led_2, seg;
  logic [5:0] an;

  int checks   = 0;
  int failures = 0;
  int t        = 0;
  int boot     = 0;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic [6:0] dec;
  } exp_t;
  exp_t sb[$];

  int sh_s = 0, sh_m = 0, sh_h = 0;

  display_scan_ctrl #(.SCAN_DIV(4), .BLINK_STEPS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hour      (hour),
    .min       (min),
    .sec       (sec),
    .blink_sel (blink_sel),
    .dec_val   (dec_val),
    .dec_led_1 (dec_led_1),
    .dec_led_2 (dec_led_2),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  // External two-digit decoder model.
  always_comb begin
    dec_led_1 = PAT[int'(dec_val) % 10];
    dec_led_2 = PAT[(int'(dec_val) / 10) % 10];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  function automatic int sat(input logic [6:0] v);
    return (int'(v) > 99) ? 99 : int'(v);
  endfunction

  function automatic int grp_val(input int g);
    return (g == 0) ? sh_s : (g == 1) ? sh_m : sh_h;
  endfunction

  // Expected output after edge t derived from cycle count since reset release.
  always @(posedge clk) begin
    exp_t e;
    int dp, ph, v, digit;
    if (!rst_n) begin
      t = 0;
      sh_s = 0; sh_m = 0; sh_h = 0;
    end else begin
      t++;
      dp    = ((t - 1) / 4) % 6;
      ph    = (((t - 1) / 4) / 3) % 2;
      v     = grp_val(dp / 2);
      digit = (dp % 2 == 1) ? v / 10 : v % 10;
      e.seg = PAT[digit];
      e.an  = ~(6'b000001 << dp);
      if (ph == 1 && int'(blink_sel) == dp / 2 + 1) begin
        e.seg = 7'h7F;
        e.an  = 6'h3F;
      end
      if (t == 1 || t % 24 == 0) begin
        sh_s = sat(sec); sh_m = sat(min); sh_h = sat(hour);
      end
      e.dec = 7'(grp_val(((t / 4) % 6) / 2));
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      check("an", 32'(an), 32'(e.an));
      check("seg", 32'(seg), 32'(e.seg));
      check("dec_val", 32'(dec_val), 32'(e.dec));
      if (boot == 1) begin
        case (t)
          2:  begin check("pwr_an0", 32'(an), 32'h3E); check("pwr_seg0", 32'(seg), 32'h02); end
          6:  begin check("pwr_an1", 32'(an), 32'h3D); check("pwr_seg1", 32'(seg), 32'h12); end
          10: begin check("pwr_an2", 32'(an), 32'h3B); check("pwr_seg2", 32'(seg), 32'h19); end
          14: begin check("pwr_an3", 32'(an), 32'h37); check("pwr_seg3", 32'(seg), 32'h30); end
          18: begin check("pwr_an4", 32'(an), 32'h2F); check("pwr_seg4", 32'(seg), 32'h24); end
          22: begin check("pwr_an5", 32'(an), 32'h1F); check("pwr_seg5", 32'(seg), 32'h79); end
          26: check("frame_sec1", 32'(seg), 32'h78);
          30: check("frame_sec10", 32'(seg), 32'h40);
          66: check("sat_hr1", 32'(seg), 32'h10);
          70: check("sat_hr10", 32'(seg), 32'h10);
          default: ;
        endcase
      end
    end
  end

  task automatic wait_t(input int target);
    for (int i = 0; i < 300 && t < target; i++) @(negedge clk);
    check("wait_t", t, target);
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0; hour = 7'd12; min = 7'd34; sec = 7'd56; blink_sel = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'h3F);
    check("rst_dec", 32'(dec_val), 32'h0);
    @(negedge clk);
    boot++;
    rst_n = 1'b1;

    wait_t(10);
    sec = 7'd7;
    wait_t(30);
    hour = 7'd120;
    wait_t(50);
    blink_sel = 2'd2;
    wait_t(120);

    // Asynchronous reset mid-step while digit 3 is active.
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (((t / 4) % 6) == 3 && (t % 4) == 1) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_wait", 32'(hit), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_an", 32'(an), 32'h3F);
    check("arst_dec", 32'(dec_val), 32'h0);
    @(negedge clk);
    @(negedge clk);
    boot++;
    rst_n = 1'b1;
    wait_t(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
